spi_slave_regfile: RTL and testbench
====================================

Name: spi_slave_regfile

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) that decodes 16-bit command/data frames from the existing SPI master into accesses to a local 8-bit register file.
- Oversamples SCLK, CS and MOSI on its own system clock; no logic is clocked by SCLK.
- Sits at the slave end of the master's link and also exposes a local parallel write/read port to core logic.

Parameters:
- ADDR_W, 3, register-file address width; depth = 2**ADDR_W registers of 8 bits.
- RST_VAL, 8'h00, reset value of every register.

Ports:
- CLK_S  input  1  system clock; must run at least 4x the SCLK frequency.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of CLK_S.
- SCLK  input  1  SPI clock from the master (asynchronous to CLK_S).
- CS  input  1  chip select, active low.
- MOSI  input  1  master-out data.
- MISO  output  1  slave-out data; driven 0 whenever it is not shifting read data.
- wr_en  input  1  local write strobe.
- wr_addr  input  ADDR_W  local write address.
- wr_data  input  8  local write data.
- rd_addr  input  ADDR_W  local read address.
- rd_data  output  8  combinational read of reg[rd_addr].
- done_S  output  1  one-cycle pulse when a 16-bit frame completes.
- abort_S  output  1  one-cycle pulse when CS rises mid-frame.
- rx_cmd  output  8  command byte of the last completed frame.
- rx_S  output  8  data byte of the last completed frame (MOSI bits).

Behaviour:
- Input sync: SCLK, CS and MOSI each pass through a 2-FF synchronizer, plus one stage for edge detect.
  - rise/fall = synchronized SCLK edges.
  - Total input latency is 3 CLK_S cycles.
- Frame format:
  - Byte 0 is the command: bit7 = 1 is a write, 0 is a read; bits[ADDR_W-1:0] are the address; remaining bits are ignored.
  - Byte 1 is data. For a write it comes from MOSI. For a read it goes to MISO while MOSI is shifted into rx_S but otherwise ignored.
- FSM states: IDLE, CMD, DATA, HOLD.
  - IDLE: wait for synchronized CS = 0, then go to CMD with bit_cnt = 0.
  - CMD: on each rise, shift MOSI into sh_rx and increment bit_cnt. On the 8th rise, latch the command, load tx_sh = reg[addr], clear bit_cnt and go to DATA.
  - DATA:
    - On each rise, shift MOSI into sh_rx and increment bit_cnt.
    - On each fall with bit_cnt ≥ 1, shift tx_sh left.
    - MISO = tx_sh[7] when the command is a read, else 0.
    - On the 8th rise: update rx_cmd and rx_S, pulse done_S, and if the command is a write set reg[addr] = data. Then go to HOLD.
  - HOLD: ignore all SCLK edges; MISO = 0; when CS = 1, go to IDLE.
- CS = 1 while in CMD or DATA: pulse abort_S, perform no register write, leave rx_cmd and rx_S unchanged, go to IDLE.
- MISO is 0 in IDLE, CMD and HOLD.
  - The first read bit is valid within 1 CLK_S cycle of the 8th command rise.
  - This is before the following fall, so the master samples it on the 9th rise.
- The register write and the done_S pulse occur in the same CLK_S cycle, 3 cycles after the 16th SCLK rise at the pins.
- Local write: wr_en writes reg[wr_addr] = wr_data on the next edge.
  - If it coincides with an SPI write to the same address, the SPI write wins.
  - Writes to different addresses both commit.
- A local write to the address of an in-flight read does not change tx_sh (snapshot at the 8th rise).
- Reset:
  - All registers = RST_VAL; MISO, done_S, abort_S = 0; rx_cmd, rx_S = 0; FSM = IDLE; synchronizers cleared.
  - Reset asserted mid-frame discards the frame without any pulse.
  - After reset releases with CS still low, the FSM enters CMD and counts from the next rise. The master must toggle CS to resynchronize.

Test Plan:
- reset, then frame 0x83,0x5A -> reg[3] = 0x5A; done_S pulses once; rx_cmd = 0x83; rx_S = 0x5A; MISO = 0 throughout the frame.
- After the previous write, frame 0x03,0x00 -> MISO shifts 0x5A (0,1,0,1,1,0,1,0) on the 9th–16th rises; done_S pulses; reg[3] is unchanged.
- Frame 0x85,0xB3 with CS raised after 5 data bits -> abort_S pulses; reg[5] stays 0x00; done_S never pulses; rx_cmd and rx_S keep their previous values.
- wr_en with wr_addr = 2, wr_data = 0x11 in the same cycle as the done_S of SPI write 0x82,0xCA -> reg[2] = 0xCA. Repeat with wr_addr = 4 -> reg[4] = 0x11 and reg[2] = 0xCA.
- Keep CS low and send 24 SCLK pulses after 0x81,0x77 -> only reg[1] = 0x77 is written; one done_S pulse; extra edges are ignored in HOLD.
- Assert reset after 12 bits of frame 0x86,0x3C, release it, then raise CS -> reg[6] = RST_VAL; no done_S or abort_S pulse; the next full frame works normally.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder: oversamples SCLK/CS/MOSI on CLK_S and turns 16-bit
// command/data frames into reads and writes of a small 8-bit register file.
module spi_slave_regfile #(
  parameter int          ADDR_W  = 3,
  parameter logic [7:0]  RST_VAL = 8'h00
) (
  input  logic              CLK_S,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              done_S,
  output logic              abort_S,
  output logic [7:0]        rx_cmd,
  output logic [7:0]        rx_S
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_rx_q, sh_rx_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  rx_cmd_q, rx_cmd_d;
  logic [7:0]  rx_s_q, rx_s_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic [7:0]  regs_q [DEPTH];
  logic [7:0]  regs_d [DEPTH];

  logic              sclk_rise, sclk_fall, cs_high, mosi_bit;
  logic [7:0]        shifted;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_waddr;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_high   = cs_sync_q[1];
  assign mosi_bit  = mosi_sync_q[1];
  assign shifted   = {sh_rx_q[6:0], mosi_bit};
  assign spi_waddr = cmd_q[ADDR_W-1:0];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    cs_sync_d   = {cs_sync_q[0], CS};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_rx_d   = sh_rx_q;
    tx_sh_d   = tx_sh_q;
    cmd_d     = cmd_q;
    rx_cmd_d  = rx_cmd_q;
    rx_s_d    = rx_s_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    spi_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_high) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
        end
      end
      CMD: begin
        if (cs_high) begin
          // A deselect before any bit arrived is not an aborted frame.
          abort_d = (bit_cnt_q != 3'd0);
          state_d = IDLE;
        end else if (sclk_rise) begin
          sh_rx_d   = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            cmd_d     = shifted;
            tx_sh_d   = regs_q[shifted[ADDR_W-1:0]];
            bit_cnt_d = 3'd0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (cs_high) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise) begin
          sh_rx_d   = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_cmd_d = cmd_q;
            rx_s_d   = shifted;
            done_d   = 1'b1;
            spi_we   = cmd_q[7];
            state_d  = HOLD;
          end
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
          // The first fall of the data byte keeps bit 7 on MISO for the 9th rise.
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
      HOLD: begin
        if (cs_high) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SPI write is applied after the local write so it wins on an address clash.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && wr_addr == ADDR_W'(i)) regs_d[i] = wr_data;
      if (spi_we && spi_waddr == ADDR_W'(i)) regs_d[i] = shifted;
    end
  end

  always_ff @(posedge CLK_S) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= 3'b000;
      // CS synchronizer resets to the deselected level so no phantom frame starts.
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      bit_cnt_q   <= 3'd0;
      sh_rx_q     <= 8'h00;
      tx_sh_q     <= 8'h00;
      cmd_q       <= 8'h00;
      rx_cmd_q    <= 8'h00;
      rx_s_q      <= 8'h00;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RST_VAL;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_rx_q     <= sh_rx_d;
      tx_sh_q     <= tx_sh_d;
      cmd_q       <= cmd_d;
      rx_cmd_q    <= rx_cmd_d;
      rx_s_q      <= rx_s_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign MISO    = (state_q == DATA && !cmd_q[7]) ? tx_sh_q[7] : 1'b0;
  assign rd_data = regs_q[rd_addr];
  assign done_S  = done_q;
  assign abort_S = abort_q;
  assign rx_cmd  = rx_cmd_q;
  assign rx_S    = rx_s_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed frames followed by random
// frames, aborts and local writes, checked against a register-array model.
module tb_spi_slave_regfile;

  localparam int         ADDR_W  = 3;
  localparam int         DEPTH   = 8;
  localparam logic [7:0] RST_VAL = 8'h00;

  logic              CLK_S = 1'b0;
  logic              reset = 1'b1;
  logic              SCLK = 1'b0;
  logic              CS = 1'b1;
  logic              MOSI = 1'b0;
  logic              MISO;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0]        wr_data = 8'h00;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic              done_S, abort_S;
  logic [7:0]        rx_cmd, rx_S;

  spi_slave_regfile #(.ADDR_W(ADDR_W), .RST_VAL(RST_VAL)) dut (
    .CLK_S(CLK_S), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .done_S(done_S), .abort_S(abort_S), .rx_cmd(rx_cmd), .rx_S(rx_S)
  );

  always #5 CLK_S = ~CLK_S;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  logic [7:0] model_reg [DEPTH];
  logic [7:0] model_rx_cmd, model_rx_s;

  always @(negedge CLK_S) begin
    if (done_S)  done_cnt++;
    if (abort_S) abort_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic half();
    repeat (6) @(negedge CLK_S);
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) model_reg[a] = RST_VAL;
    model_rx_cmd = 8'h00;
    model_rx_s   = 8'h00;
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = ADDR_W'(a);
      #1;
      check($sformatf("%s_reg%0d", tag, a), rd_data, model_reg[a]);
    end
  endtask

  task automatic local_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge CLK_S);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge CLK_S);
    wr_en = 1'b0;
    model_reg[a] = d;
    $display("local write addr=%0d data=%02h", a, d);
  endtask

  // nbits < 16 with end_cs raises CS mid-frame; lw fires a local write on the commit edge.
  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                           input int extra, input bit lw, input logic [ADDR_W-1:0] lw_addr,
                           input logic [7:0] lw_data, input bit end_cs);
    logic [15:0]       bits;
    logic [7:0]        miso_byte, exp_miso;
    logic              early, hold_miso;
    logic [ADDR_W-1:0] addr;
    int                d0, a0;
    bit                full;
    bits = {cmd, dat};
    miso_byte = 8'h00; early = 1'b0; hold_miso = 1'b0;
    addr = cmd[ADDR_W-1:0];
    full = (nbits == 16);
    exp_miso = cmd[7] ? 8'h00 : model_reg[addr];
    d0 = done_cnt; a0 = abort_cnt;
    CS = 1'b0;
    half();
    for (int i = 0; i < nbits; i++) begin
      MOSI = bits[15-i];
      half();
      if (i < 8) early = early | MISO;
      else miso_byte[15-i] = MISO;
      SCLK = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge CLK_S);
        if (i == 15 && k == 2) begin
          check("done_early", done_S, 8'h00);
          if (lw) begin wr_en = 1'b1; wr_addr = lw_addr; wr_data = lw_data; end
        end
        if (i == 15 && k == 3) begin
          wr_en = 1'b0;
          check("done_lat", done_S, 8'h01);
        end
      end
      SCLK = 1'b0;
    end
    half();
    for (int e = 0; e < extra; e++) begin
      MOSI = 1'($urandom);
      half();
      hold_miso = hold_miso | MISO;
      SCLK = 1'b1;
      half();
      SCLK = 1'b0;
    end
    if (end_cs) begin
      CS = 1'b1;
      half();
    end
    if (full) begin
      if (lw) model_reg[lw_addr] = lw_data;
      if (cmd[7]) model_reg[addr] = dat;
      model_rx_cmd = cmd;
      model_rx_s   = dat;
    end
    $display("frame cmd=%02h data=%02h bits=%0d extra=%0d miso=%02h", cmd, dat, nbits, extra, miso_byte);
    check("miso_cmd", 8'(early), 8'h00);
    if (full) check("miso_data", miso_byte, exp_miso);
    if (extra > 0) check("miso_hold", 8'(hold_miso), 8'h00);
    if (end_cs) begin
      check("done_cnt", 8'(done_cnt - d0), full ? 8'h01 : 8'h00);
      check("abort_cnt", 8'(abort_cnt - a0), (!full && nbits > 0) ? 8'h01 : 8'h00);
    end
    check("rx_cmd", rx_cmd, model_rx_cmd);
    check("rx_S", rx_S, model_rx_s);
  endtask

  initial begin
    int d0, a0, nb;
    logic [7:0] c, d;
    model_reset();
    repeat (5) @(negedge CLK_S);
    reset = 1'b0;
    repeat (3) @(negedge CLK_S);
    check("rst_miso", 8'(MISO), 8'h00);
    check("rst_done", 8'(done_S), 8'h00);
    check("rst_abort", 8'(abort_S), 8'h00);
    check("rst_rx_cmd", rx_cmd, 8'h00);
    check("rst_rx_S", rx_S, 8'h00);
    check_regs("rst");

    spi_frame(8'h83, 8'h5A, 16, 0, 1'b0, '0, 8'h00, 1'b1);
    check_regs("wr3");
    spi_frame(8'h03, 8'h00, 16, 0, 1'b0, '0, 8'h00, 1'b1);
    check_regs("rd3");
    spi_frame(8'h85, 8'hB3, 13, 0, 1'b0, '0, 8'h00, 1'b1);
    check_regs("abort");
    spi_frame(8'h82, 8'hCA, 16, 0, 1'b1, 3'd2, 8'h11, 1'b1);
    check_regs("clash");
    spi_frame(8'h82, 8'hCA, 16, 0, 1'b1, 3'd4, 8'h11, 1'b1);
    check_regs("both");
    spi_frame(8'h81, 8'h77, 16, 24, 1'b0, '0, 8'h00, 1'b1);
    check_regs("hold");

    d0 = done_cnt; a0 = abort_cnt;
    spi_frame(8'h86, 8'h3C, 12, 0, 1'b0, '0, 8'h00, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge CLK_S);
    reset = 1'b0;
    model_reset();
    half();
    CS = 1'b1;
    repeat (12) @(negedge CLK_S);
    $display("reset mid-frame then CS release");
    check("mid_rst_done", 8'(done_cnt - d0), 8'h00);
    check("mid_rst_abort", 8'(abort_cnt - a0), 8'h00);
    check("mid_rst_rx_cmd", rx_cmd, 8'h00);
    check_regs("midrst");
    spi_frame(8'h86, 8'h3C, 16, 0, 1'b0, '0, 8'h00, 1'b1);
    check_regs("post");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) local_write(ADDR_W'($urandom), 8'($urandom));
      c  = 8'($urandom);
      d  = 8'($urandom);
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
      spi_frame(c, d, nb, 0, 1'b0, '0, 8'h00, 1'b1);
    end
    check_regs("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
